// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: request/grant sequencer for the shared single-port
// memory; fetch and data paths, exactly one transaction in flight.
module mem_port_arbiter #(
  parameter int AW         = 8,
  parameter int DW         = 8,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  output logic          mem_re,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int LW = 3;
  localparam int SW = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMD,
    S_WAIT,
    S_RESP
  } state_t;

  state_t          r_state;
  state_t          w_state_n;
  logic            r_fetch;
  logic            w_fetch_n;
  logic            r_store;
  logic            w_store_n;
  logic [LW-1:0]   r_lat;
  logic [LW-1:0]   w_lat_n;
  logic [SW-1:0]   r_starve;
  logic [SW-1:0]   w_starve_n;
  logic            r_if_gnt;
  logic            w_if_gnt_n;
  logic            r_d_gnt;
  logic            w_d_gnt_n;
  logic            r_if_rv;
  logic            w_if_rv_n;
  logic            r_d_rv;
  logic            w_d_rv_n;
  logic [DW-1:0]   r_rdata;
  logic [DW-1:0]   w_rdata_n;
  logic [AW-1:0]   r_mem_addr;
  logic [AW-1:0]   w_addr_n;
  logic [DW-1:0]   r_mem_wdata;
  logic [DW-1:0]   w_wdata_n;
  logic            r_mem_we;
  logic            w_mem_we_n;
  logic            r_mem_re;
  logic            w_mem_re_n;
  logic            r_busy;
  logic            w_busy_n;
  logic            w_any;
  logic            w_starve_max;
  logic            w_pick_if;

  // data wins unless fetch has waited through STARVE_MAX data grants
  assign w_any        = if_req | d_req;
  assign w_starve_max = (r_starve == SW'(STARVE_MAX));
  assign w_pick_if    = if_req & (~d_req | w_starve_max);
  assign w_busy_n     = (w_state_n != S_IDLE);

  // next-state and next-output decode; all outputs are registered
  always_comb begin
    w_state_n  = r_state;
    w_fetch_n  = r_fetch;
    w_store_n  = r_store;
    w_lat_n    = r_lat;
    w_starve_n = r_starve;
    w_addr_n   = r_mem_addr;
    w_wdata_n  = r_mem_wdata;
    w_rdata_n  = r_rdata;
    w_if_gnt_n = 1'b0;
    w_d_gnt_n  = 1'b0;
    w_if_rv_n  = 1'b0;
    w_d_rv_n   = 1'b0;
    w_mem_we_n = 1'b0;
    w_mem_re_n = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_n  = S_CMD;
          w_fetch_n  = w_pick_if;
          w_store_n  = ~w_pick_if & d_we;
          w_if_gnt_n = w_pick_if;
          w_d_gnt_n  = ~w_pick_if;
          w_mem_we_n = ~w_pick_if & d_we;
          w_mem_re_n = w_pick_if | ~d_we;
          if (w_pick_if) begin
            w_addr_n   = if_addr;
            w_starve_n = '0;
          end else begin
            w_addr_n  = d_addr;
            w_wdata_n = d_wdata;
            if (!if_req) begin
              w_starve_n = '0;
            end else if (!w_starve_max) begin
              w_starve_n = r_starve + 1'b1;
            end
          end
        end
      end
      S_CMD: begin
        if (r_store) begin
          w_state_n = S_IDLE;
        end else begin
          w_state_n = S_WAIT;
          w_lat_n   = LW'(RD_LAT);
        end
      end
      S_WAIT: begin
        if (r_lat == LW'(1)) begin
          w_state_n = S_RESP;
          w_rdata_n = mem_rdata;
          w_if_rv_n = r_fetch;
          w_d_rv_n  = ~r_fetch;
        end else begin
          w_lat_n = r_lat - LW'(1);
        end
      end
      S_RESP: begin
        w_state_n = S_IDLE;
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase
  end

  // state and output registers; reset abandons any transaction
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_fetch     <= 1'b0;
      r_store     <= 1'b0;
      r_lat       <= '0;
      r_starve    <= '0;
      r_if_gnt    <= 1'b0;
      r_d_gnt     <= 1'b0;
      r_if_rv     <= 1'b0;
      r_d_rv      <= 1'b0;
      r_rdata     <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
      r_mem_re    <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_fetch     <= w_fetch_n;
      r_store     <= w_store_n;
      r_lat       <= w_lat_n;
      r_starve    <= w_starve_n;
      r_if_gnt    <= w_if_gnt_n;
      r_d_gnt     <= w_d_gnt_n;
      r_if_rv     <= w_if_rv_n;
      r_d_rv      <= w_d_rv_n;
      r_rdata     <= w_rdata_n;
      r_mem_addr  <= w_addr_n;
      r_mem_wdata <= w_wdata_n;
      r_mem_we    <= w_mem_we_n;
      r_mem_re    <= w_mem_re_n;
      r_busy      <= w_busy_n;
    end
  end

  assign if_gnt    = r_if_gnt;
  assign d_gnt     = r_d_gnt;
  assign if_rvalid = r_if_rv;
  assign d_rvalid  = r_d_rv;
  assign rdata     = r_rdata;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_we    = r_mem_we;
  assign mem_re    = r_mem_re;
  assign busy      = r_busy;

endmodule
